// File: rtl/led_pwm_bank.sv
// ---------------------------------------------------------------------------
// led_pwm_bank
//
// Multi-channel LED PWM driver. A shared prescaler and phase counter define
// one PWM period of DIV*STEPS clocks. Each channel has a shadow duty register,
// written at run time, and an active duty register that is reloaded from the
// shadow only at the period boundary. Because of this, duty changes never
// glitch a period that is already in progress.
//
// Optional feature macro: LED_PWM_BREATHE_EN
//   When it is defined, the block adds the Breathe port and a per-channel
//   triangle ramp. While a channel's Breathe bit is high, its active duty
//   steps 0,1,..,STEPS,STEPS-1,..,0,.. with one step per period. The shadow
//   register of that channel is still written, but it is not used until
//   Breathe falls.
//
// Parameters
//   CH        number of channels (1..16)
//   CLK_HZ    input clock frequency
//   PWM_HZ    PWM period frequency
//   STEPS     duty resolution, in steps per period
//   DUTY_INIT reset duty for every channel, in steps (saturated to STEPS)
//   DIV = CLK_HZ/(PWM_HZ*STEPS) must be at least 2.
//
// Ports
//   Clk_50M  in   system clock
//   Rst      in   asynchronous active-high reset
//   Sw       in   [CH]  per-channel enable switches (asynchronous, synchronised here)
//   Wr_en    in   single-cycle duty write strobe
//   Wr_ch    in   [CW]  target channel; writes to a channel >= CH are ignored
//   Wr_duty  in   [DW]  duty in steps; values above STEPS are saturated
//   Breathe  in   [CH]  breathing-mode select (only with LED_PWM_BREATHE_EN)
//   Led      out  [CH]  registered LED drive
//   Frame    out  one-cycle pulse in the cycle where phase first reads 0
// ---------------------------------------------------------------------------
module led_pwm_bank #(
  parameter int CH        = 4,
  parameter int CLK_HZ    = 50_000_000,
  parameter int PWM_HZ    = 50,
  parameter int STEPS     = 100,
  parameter int DUTY_INIT = 10,
  localparam int DIV      = CLK_HZ / (PWM_HZ * STEPS),
  localparam int DW       = $clog2(STEPS + 1),
  localparam int CW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          Clk_50M,
  input  logic          Rst,
  input  logic [CH-1:0] Sw,
  input  logic          Wr_en,
  input  logic [CW-1:0] Wr_ch,
  input  logic [DW-1:0] Wr_duty,
`ifdef LED_PWM_BREATHE_EN
  input  logic [CH-1:0] Breathe,
`endif
  output logic [CH-1:0] Led,
  output logic          Frame
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [DW-1:0]    PH_MAX  = DW'(STEPS - 1);
  localparam logic [DW-1:0]    STEPS_V = DW'(STEPS);
  localparam logic [DW-1:0]    INIT_V  = DW'((DUTY_INIT > STEPS) ? STEPS : DUTY_INIT);

  logic [PRE_W-1:0] pre;
  logic [DW-1:0]    phase;
  logic             tick;
  logic             bnd;

  logic [CH-1:0]    sw_m;
  logic [CH-1:0]    sw_s;

  logic [DW-1:0]    shadow [CH];
  logic [DW-1:0]    active [CH];
  logic [DW-1:0]    wr_sat;

  assign tick   = (pre == PRE_MAX);
  assign bnd    = tick && (phase == PH_MAX);
  assign wr_sat = (Wr_duty > STEPS_V) ? STEPS_V : Wr_duty;

  // -------------------------------------------------------------------------
  // Timebase: prescaler and shared phase counter
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the edge; the order of the blocks does not matter.
  always_ff @(posedge Clk_50M or posedge Rst) begin
    if (Rst) begin
      pre   <= '0;
      phase <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        phase <= (phase == PH_MAX) ? '0 : phase + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Two-flop synchroniser for the switch inputs
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk_50M or posedge Rst) begin
    if (Rst) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= Sw;
      sw_s <= sw_m;
    end
  end

  // -------------------------------------------------------------------------
  // Shadow duty registers. The channel decode compares against each legal
  // index, so an out-of-range Wr_ch matches nothing and the write is ignored.
  // -------------------------------------------------------------------------
  // NOTE: this small register array gets an explicit reset because it must
  // come up holding DUTY_INIT. A larger RAM-style array that needs no defined
  // start value would be left unreset.
  always_ff @(posedge Clk_50M or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < CH; i++) shadow[i] <= INIT_V;
    end else if (Wr_en) begin
      for (int i = 0; i < CH; i++) begin
        if (Wr_ch == CW'(i)) shadow[i] <= wr_sat;
      end
    end
  end

`ifdef LED_PWM_BREATHE_EN
  // -------------------------------------------------------------------------
  // Breathing ramp: level is the duty loaded at the next boundary. When the
  // ramp reaches an end it turns around, so each end value is loaded for
  // exactly one period. A channel that is not breathing is held at level 0,
  // direction up, so it restarts cleanly.
  // -------------------------------------------------------------------------
  logic [DW-1:0] level [CH];
  logic [CH-1:0] up;

  always_ff @(posedge Clk_50M or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < CH; i++) level[i] <= '0;
      up <= '1;
    end else if (bnd) begin
      for (int i = 0; i < CH; i++) begin
        if (!Breathe[i]) begin
          level[i] <= '0;
          up[i]    <= 1'b1;
        end else if (up[i]) begin
          if (level[i] == STEPS_V) begin
            level[i] <= PH_MAX;
            up[i]    <= 1'b0;
          end else begin
            level[i] <= level[i] + 1'b1;
          end
        end else begin
          if (level[i] == '0) begin
            level[i] <= DW'(1);
            up[i]    <= 1'b1;
          end else begin
            level[i] <= level[i] - 1'b1;
          end
        end
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Active duty: reloaded only at the period boundary. The shadow is sampled
  // before any write in the same cycle, so such a write waits one period.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk_50M or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < CH; i++) active[i] <= INIT_V;
    end else if (bnd) begin
      for (int i = 0; i < CH; i++) begin
`ifdef LED_PWM_BREATHE_EN
        active[i] <= Breathe[i] ? level[i] : shadow[i];
`else
        active[i] <= shadow[i];
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs. With duty == STEPS the compare is true on every
  // phase, so the LED stays high with no gap at the boundary.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk_50M or posedge Rst) begin
    if (Rst) begin
      Led   <= '0;
      Frame <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) Led[i] <= sw_s[i] & (phase < active[i]);
      Frame <= bnd;
    end
  end

endmodule
